// File: rtl/pe_result_drain.sv
// Result drain behind the PE array. A start pulse snapshots every accumulator.
// Each value is requantized to signed INT8, then streamed out one PE row per valid/ready beat.

module pe_requant_lane #(
  parameter int INT8      = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic [ACC_WIDTH-1:0] i_acc,
  input  logic                 i_vis,
  input  logic [4:0]           i_shift,
  output logic [INT8-1:0]      o_q,
  output logic                 o_sat
);
  localparam logic signed [ACC_WIDTH-1:0] QMAX = ACC_WIDTH'((2**(INT8-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] QMIN = ~QMAX;

  logic signed [ACC_WIDTH-1:0] w_v;
  logic                        w_hi;
  logic                        w_lo;

  assign w_v  = $signed(i_acc) >>> i_shift;
  assign w_hi = w_v > QMAX;
  assign w_lo = w_v < QMIN;

  // Masked lanes drive zero and never report saturation.
  assign o_q   = !i_vis ? '0 :
                 w_hi   ? QMAX[INT8-1:0] :
                 w_lo   ? QMIN[INT8-1:0] : w_v[INT8-1:0];
  assign o_sat = i_vis & (w_hi | w_lo);
endmodule

module pe_result_drain #(
  parameter int INT8            = 8,
  parameter int NUM_PEs_PER_ROW = 5,
  parameter int NUM_ROWS        = 5,
  parameter int ACC_WIDTH       = 32,
  parameter int ROW_W           = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start_i,
  input  logic [NUM_ROWS*NUM_PEs_PER_ROW*ACC_WIDTH-1:0] pe_acc_i,
  input  logic [NUM_ROWS*NUM_PEs_PER_ROW-1:0]        visible_i,
  input  logic [4:0]                                 shift_i,
  output logic                                       busy,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [NUM_PEs_PER_ROW*INT8-1:0]            out_data,
  output logic [ROW_W-1:0]                           out_row,
  output logic                                       sat_o,
  output logic                                       done
);
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

  state_t                                                      r_state;
  logic [NUM_ROWS-1:0][NUM_PEs_PER_ROW-1:0][ACC_WIDTH-1:0]     r_acc;
  logic [NUM_ROWS-1:0][NUM_PEs_PER_ROW-1:0]                    r_vis;
  logic [4:0]                                                  r_shift;
  logic [ROW_W-1:0]                                            r_ptr;

  logic [NUM_PEs_PER_ROW-1:0][ACC_WIDTH-1:0] w_row_acc;
  logic [NUM_PEs_PER_ROW-1:0]                w_row_vis;
  logic [NUM_PEs_PER_ROW-1:0][INT8-1:0]      w_q;
  logic [NUM_PEs_PER_ROW-1:0]                w_sat;
  logic                                      w_xfer;
  logic                                      w_last;

  assign w_row_acc = r_acc[r_ptr];
  assign w_row_vis = r_vis[r_ptr];
  assign w_xfer    = out_valid & out_ready;
  assign w_last    = (r_ptr == ROW_W'(NUM_ROWS - 1));

  genvar c;
  generate
    for (c = 0; c < NUM_PEs_PER_ROW; c++) begin : g_lane
      pe_requant_lane #(.INT8(INT8), .ACC_WIDTH(ACC_WIDTH)) u_lane (
        .i_acc   (w_row_acc[c]),
        .i_vis   (w_row_vis[c]),
        .i_shift (r_shift),
        .o_q     (w_q[c]),
        .o_sat   (w_sat[c])
      );
    end
  endgenerate

  // Data is a pure function of the held snapshot and row pointer, so it is stable under backpressure.
  assign out_data = out_valid ? w_q : '0;
  assign out_row  = r_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_vis     <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      sat_o     <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start_i) begin
            r_acc     <= pe_acc_i;
            r_vis     <= visible_i;
            r_shift   <= shift_i;
            r_ptr     <= '0;
            sat_o     <= 1'b0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            r_state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_xfer) begin
            sat_o <= sat_o | (|w_sat);
            if (w_last) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_ptr <= r_ptr + ROW_W'(1);
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_ptr   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end
endmodule
